// File: rtl/fabric_port_arbiter_pkg.sv
// Shared definitions for fabric port arbitration: FSM encodings and the
// default watchdog length used by every fabric slave port.
package fabric_port_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Busy cycles before a stuck grant is forcibly revoked; 0 disables it.
  localparam int TMO_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/fabric_rr_pick.sv
// Combinational rotating-priority encoder. Scans req starting at ptr and
// moving upward, wrapping at NMASTERS-1 -> 0, and returns the first set bit.
// Kept free of state so other fabric ports can reuse it.
module fabric_rr_pick #(
  parameter int NMASTERS  = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NMASTERS-1:0]  req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic                 any,
  output logic [IDX_WIDTH-1:0] idx
);

  logic [2*NMASTERS-1:0] req_dbl;
  logic [NMASTERS-1:0]   req_rot;

  // Rotate so that position 0 of req_rot corresponds to master ptr.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[NMASTERS-1:0];

  // Priority-encode the rotated vector, then map the offset back to a master index.
  always_comb begin
    logic [IDX_WIDTH:0] sum;
    // NOTE: every output of a combinational block gets a default on entry,
    // otherwise paths that skip an assignment infer a latch.
    sum = '0;
    any = 1'b0;
    idx = '0;
    // Scan from the highest offset down so the lowest offset is assigned last and wins.
    for (int off = NMASTERS - 1; off >= 0; off--) begin
      if (req_rot[off]) begin
        sum = {1'b0, ptr} + (IDX_WIDTH + 1)'(off);
        if (sum >= (IDX_WIDTH + 1)'(NMASTERS)) begin
          sum = sum - (IDX_WIDTH + 1)'(NMASTERS);
        end
        any = 1'b1;
        idx = sum[IDX_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/fabric_port_arbiter.sv
// Round-robin arbiter for one shared fabric slave port. A grant is held from
// its first cycle until the slave reports completion (i_done) or the watchdog
// revokes it; completion re-arbitrates in the same cycle with no idle bubble.
module fabric_port_arbiter
  import fabric_port_arbiter_pkg::*;
#(
  parameter int NMASTERS   = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int TMO_WIDTH  = 8,
  parameter int TMO_CYCLES = TMO_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NMASTERS-1:0]  i_req,
  input  logic                 i_done,
  output logic [NMASTERS-1:0]  o_gnt,
  output logic [IDX_WIDTH-1:0] o_gnt_idx,
  output logic                 o_busy,
  output logic                 o_tmo,
  output logic [IDX_WIDTH-1:0] o_tmo_idx
);

  localparam bit                   TMO_EN   = (TMO_CYCLES != 0);
  // Counter value seen on the last busy cycle before the forced release.
  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TMO_CYCLES - 1);
  localparam logic [TMO_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NMASTERS - 1);

  arb_state_e           state_q,   state_d;
  logic [NMASTERS-1:0]  gnt_q,     gnt_d;
  logic [IDX_WIDTH-1:0] gnt_idx_q, gnt_idx_d;
  logic                 busy_q,    busy_d;
  logic                 tmo_q,     tmo_d;
  logic [IDX_WIDTH-1:0] tmo_idx_q, tmo_idx_d;
  logic [IDX_WIDTH-1:0] rr_ptr_q,  rr_ptr_d;
  logic [TMO_WIDTH-1:0] cnt_q,     cnt_d;

  logic                 pick_any;
  logic [IDX_WIDTH-1:0] pick_idx;
  logic                 tmo_hit;

  fabric_rr_pick #(
    .NMASTERS  (NMASTERS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pick (
    .req (i_req),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign tmo_hit = TMO_EN && (cnt_q == TMO_LAST);

  // Next-state logic: arbitrate from IDLE or on completion, count busy cycles, revoke on timeout.
  always_comb begin
    logic grant_new;
    grant_new = 1'b0;
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    busy_d    = busy_q;
    tmo_d     = 1'b0;
    tmo_idx_d = tmo_idx_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      ARB_IDLE: begin
        // A stray i_done here has no owner to release and is ignored.
        grant_new = pick_any;
      end
      ARB_BUSY: begin
        if (i_done) begin
          // Completion beats a coinciding timeout; hand over directly if anyone waits.
          if (pick_any) begin
            grant_new = 1'b1;
          end else begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end else if (tmo_hit) begin
          state_d   = ARB_IDLE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          cnt_d     = '0;
          tmo_d     = 1'b1;
          tmo_idx_d = gnt_idx_q;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    if (grant_new) begin
      state_d           = ARB_BUSY;
      gnt_d             = '0;
      gnt_d[pick_idx]   = 1'b1;
      gnt_idx_d         = pick_idx;
      busy_d            = 1'b1;
      cnt_d             = '0;
      rr_ptr_d          = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
    end
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      busy_q    <= 1'b0;
      tmo_q     <= 1'b0;
      tmo_idx_q <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      busy_q    <= busy_d;
      tmo_q     <= tmo_d;
      tmo_idx_q <= tmo_idx_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_gnt     = gnt_q;
  assign o_gnt_idx = gnt_idx_q;
  assign o_busy    = busy_q;
  assign o_tmo     = tmo_q;
  assign o_tmo_idx = tmo_idx_q;

endmodule

// File: tb/tb_fabric_port_arbiter.sv
// Directed testbench for fabric_port_arbiter with a short watchdog (8 cycles).
module tb_fabric_port_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] i_req;
  logic       i_done;
  logic [3:0] o_gnt;
  logic [1:0] o_gnt_idx;
  logic       o_busy;
  logic       o_tmo;
  logic [1:0] o_tmo_idx;

  int n_checks = 0;
  int n_fail   = 0;

  fabric_port_arbiter #(
    .NMASTERS   (4),
    .IDX_WIDTH  (2),
    .TMO_WIDTH  (8),
    .TMO_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_done    (i_done),
    .o_gnt     (o_gnt),
    .o_gnt_idx (o_gnt_idx),
    .o_busy    (o_busy),
    .o_tmo     (o_tmo),
    .o_tmo_idx (o_tmo_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and land just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_gnt(input string tag, input logic [3:0] gnt, input logic [1:0] idx,
                           input logic busy);
    check({tag, "_gnt"},  32'(o_gnt),     32'(gnt));
    check({tag, "_idx"},  32'(o_gnt_idx), 32'(idx));
    check({tag, "_busy"}, 32'(o_busy),    32'(busy));
  endtask

  // Invariants sampled on the falling edge, away from state changes.
  always @(negedge clk) begin
    check("inv_onehot", 32'($onehot0(o_gnt)), 32'd1);
    check("inv_busy",   32'(o_busy),          32'(|o_gnt));
    check("inv_gidx",   32'(o_gnt[o_gnt_idx]), 32'(o_busy));
  end

  // Hard stop in case a bug stalls the stimulus.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst    = 1'b1;
    i_req  = 4'b0000;
    i_done = 1'b0;
    step();
    step();
    // Reset state
    check_gnt("rst", 4'b0000, 2'd0, 1'b0);
    check("rst_tmo",     32'(o_tmo),     32'd0);
    check("rst_tmo_idx", 32'(o_tmo_idx), 32'd0);
    rst = 1'b0;

    // 1: first grant with 1-cycle latency, pointer moves to 1
    i_req = 4'b0101;
    step();
    check_gnt("t1_first", 4'b0001, 2'd0, 1'b1);
    i_done = 1'b1;
    step();
    i_done = 1'b0;
    check_gnt("t1_ptr1", 4'b0100, 2'd2, 1'b1);
    i_req  = 4'b0000;
    i_done = 1'b1;
    step();
    i_done = 1'b0;
    check_gnt("t1_idle", 4'b0000, 2'd2, 1'b0);

    // 2: fairness from a fresh reset, done every 3rd busy cycle
    rst = 1'b1;
    step();
    rst   = 1'b0;
    i_req = 4'b1111;
    step();
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 3; k++) begin
        check_gnt($sformatf("t2_g%0d_c%0d", g, k), 4'b0001 << (g % 4), 2'(g % 4), 1'b1);
        if (k == 2) i_done = 1'b1;
        step();
        i_done = 1'b0;
      end
    end
    check_gnt("t2_next", 4'b0010, 2'd1, 1'b1);
    i_req  = 4'b0000;
    i_done = 1'b1;
    step();
    i_done = 1'b0;
    check_gnt("t2_idle", 4'b0000, 2'd1, 1'b0);

    // 3: grant locked while owner drops request and others request
    i_req = 4'b0100;
    step();
    check_gnt("t3_own2", 4'b0100, 2'd2, 1'b1);
    i_req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      step();
      check_gnt($sformatf("t3_lock%0d", k), 4'b0100, 2'd2, 1'b1);
    end
    i_done = 1'b1;
    step();
    i_done = 1'b0;
    check_gnt("t3_after", 4'b1000, 2'd3, 1'b1);
    i_req  = 4'b0000;
    i_done = 1'b1;
    step();
    i_done = 1'b0;
    check_gnt("t3_idle", 4'b0000, 2'd3, 1'b0);

    // 4: watchdog revokes grant of master 1 eight cycles after the grant
    i_req = 4'b0010;
    step();
    check_gnt("t4_own1", 4'b0010, 2'd1, 1'b1);
    for (int k = 1; k < 8; k++) begin
      step();
      check($sformatf("t4_busy%0d", k), 32'(o_busy), 32'd1);
      check($sformatf("t4_tmo%0d", k),  32'(o_tmo),  32'd0);
    end
    step();
    check("t4_tmo_pulse", 32'(o_tmo),     32'd1);
    check("t4_tmo_idx",   32'(o_tmo_idx), 32'd1);
    check("t4_tmo_busy",  32'(o_busy),    32'd0);
    check("t4_tmo_gnt",   32'(o_gnt),     32'd0);
    step();
    check("t4_tmo_clr", 32'(o_tmo), 32'd0);
    check_gnt("t4_regrant", 4'b0010, 2'd1, 1'b1);

    // 5: i_done on the expiry cycle wins over the watchdog
    for (int k = 1; k < 8; k++) begin
      step();
    end
    check("t5_pre_tmo", 32'(o_tmo), 32'd0);
    i_req  = 4'b0110;
    i_done = 1'b1;
    step();
    i_done = 1'b0;
    check("t5_no_tmo", 32'(o_tmo), 32'd0);
    check_gnt("t5_rearb", 4'b0100, 2'd2, 1'b1);
    check("t5_tmo_idx_held", 32'(o_tmo_idx), 32'd1);
    i_req  = 4'b0000;
    i_done = 1'b1;
    step();
    check_gnt("t5_idle", 4'b0000, 2'd2, 1'b0);
    // i_done while idle stays idle
    step();
    i_done = 1'b0;
    check_gnt("t5_idle_done", 4'b0000, 2'd2, 1'b0);
    check("t5_idle_tmo", 32'(o_tmo), 32'd0);
    i_req = 4'b1111;
    step();
    check_gnt("t5_ptr3", 4'b1000, 2'd3, 1'b1);

    // 6: asynchronous reset mid-transaction drops the grant at once
    #2;
    rst = 1'b1;
    #1;
    check_gnt("t6_async", 4'b0000, 2'd0, 1'b0);
    check("t6_tmo_idx", 32'(o_tmo_idx), 32'd0);
    step();
    rst = 1'b0;
    step();
    check_gnt("t6_ptr0", 4'b0001, 2'd0, 1'b1);

    i_req = 4'b0000;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
